ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and HI/LO word width.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 6, pipeline stall vector: bit3 = EX stalled, bit4 = MEM stalled.
REQ-006 SHALL have port flush, input, 1, discard the in-flight instruction.
REQ-007 SHALL have ports ex_wd / ex_wreg / ex_wdata, inputs, REG_AW/1/DATA_W, EX destination, write enable and result.
REQ-008 SHALL have ports ex_whilo / ex_hi / ex_lo, inputs, 1/DATA_W/DATA_W, EX HI/LO write request and values.
REQ-009 SHALL have ports hilo_i / cnt_i, inputs, 2*DATA_W/2, EX multi-cycle accumulate partial result and step count.
REQ-010 SHALL have ports mem_wd / mem_wreg / mem_wdata, outputs, REG_AW/1/DATA_W, registered to MEM.
REQ-011 SHALL have ports mem_whilo / mem_hi / mem_lo, outputs, 1/DATA_W/DATA_W, registered to MEM.
REQ-012 SHALL have ports hilo_o / cnt_o, outputs, 2*DATA_W/2, registered partial result and step count returned to EX.

Function
REQ-013 SHALL update every register only on rising clk; no combinational path from any input to any output.
REQ-014 SHALL apply priority rst > flush > stall > normal advance.
REQ-015 Normal advance (stall[3]=0): SHALL capture all ex_* into mem_* with one-cycle latency, and SHALL clear hilo_o to 0 and cnt_o to 0.
REQ-016 Bubble (stall[3]=1, stall[4]=0): SHALL drive mem_wreg=0, mem_whilo=0, mem_wd=0, mem_wdata/mem_hi/mem_lo=0; SHALL load hilo_o<=hilo_i and cnt_o<=cnt_i.
REQ-017 Hold (stall[3]=1, stall[4]=1): SHALL keep every output register at its current value, including hilo_o and cnt_o.
REQ-018 stall[3]=0 with stall[4]=1 is illegal; SHALL behave as normal advance (REQ-015).
REQ-019 Flush: SHALL zero all mem_* outputs, hilo_o and cnt_o in the same edge, regardless of stall.
REQ-020 SHALL pass data unmodified; no width conversion, sign change or arithmetic.
REQ-021 Bits of stall other than 3 and 4 SHALL be ignored.

Reset
REQ-022 On rst=1 at a rising edge, every output SHALL become 0 (mem_wreg=0, mem_whilo=0, all data/address 0, hilo_o=0, cnt_o=0).
REQ-023 Reset asserted mid multi-cycle accumulate SHALL discard the partial result (cnt_o=0 next cycle).

Configuration
REQ-024 Macro EX_MEM_MADD_EN defined: hilo_o/cnt_o registers SHALL exist and behave per REQ-015..019.
REQ-025 Macro EX_MEM_MADD_EN undefined: hilo_o and cnt_o SHALL be constant 0, no registers inferred; hilo_i/cnt_i unused; mem_* behaviour unchanged.

Structure
REQ-026 Stall bit indices (EX=3, MEM=4), widths and zero constants SHALL live in shared package cpu_defs_pkg.
REQ-027 SHALL be a single flat module; no sub-module.

Verification
REQ-028 rst=1 one cycle with ex_wdata=0xDEADBEEF, ex_wreg=1 -> next cycle all outputs 0.
REQ-029 stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x12345678 -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0x12345678, cnt_o=0.
REQ-030 stall=6'b001000, hilo_i=0x00000001_FFFFFFFE, cnt_i=1, ex_wreg=1 -> mem_wreg=0, mem_wdata=0, hilo_o=0x00000001_FFFFFFFE, cnt_o=1.
REQ-031 stall=6'b011000 for 3 cycles after loading mem_wdata=0xA5A5A5A5 -> mem_wdata and hilo_o unchanged all 3 cycles.
REQ-032 flush=1 with stall=6'b011000, ex_whilo=1, ex_hi=0x1 -> next cycle mem_whilo=0, mem_hi=0, cnt_o=0.
REQ-033 Build without EX_MEM_MADD_EN, repeat REQ-030 -> hilo_o=0, cnt_o=0, mem_* as REQ-030.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared CPU pipeline definitions used by the EX/MEM pipeline register and
// its bus interface.
//   - stall vector width and the bit positions that mean "EX stalled" and
//     "MEM stalled"
//   - default datapath / register-address widths and the accumulate step
//     counter width
//   - zero constants for the widest fields
//   - the per-edge action decoder that turns flush/stall into one of four
//     pipeline-register behaviours
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    localparam int STALL_W    = 6;
    localparam int STALL_EX   = 3;
    localparam int STALL_MEM  = 4;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W      = 2;

    localparam logic [2*DATA_W_DEF-1:0] ZERO_HILO = '0;
    localparam logic [CNT_W-1:0]        ZERO_CNT  = '0;

    // What the pipeline register does on the next rising edge (reset is
    // handled separately because it overrides everything, including flush).
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // Flush beats stall. When EX is running the stage advances, even if MEM
    // claims to be stalled: that combination cannot occur in a well-formed
    // pipeline, so it is folded into the ordinary advance case. Only bits
    // STALL_EX and STALL_MEM of the stall vector matter.
    function automatic stage_act_e decode_action(input logic flush,
                                                 input logic [STALL_W-1:0] stall);
        stage_act_e act;
        act = ACT_ADVANCE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall[STALL_EX] && stall[STALL_MEM]) begin
            act = ACT_HOLD;
        end else if (stall[STALL_EX]) begin
            act = ACT_BUBBLE;
        end
        return act;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ---------------------------------------------------------------------------
// ex_mem_if
// Bundle of signals crossing the EX/MEM pipeline register.
//   EX side  : ex_wd, ex_wreg, ex_wdata      destination, write enable, result
//              ex_whilo, ex_hi, ex_lo        HI/LO write request and values
//              hilo_i, cnt_i                 multi-cycle accumulate partial
//                                            result and step count
//   MEM side : mem_wd, mem_wreg, mem_wdata   registered copies for MEM
//              mem_whilo, mem_hi, mem_lo
//   back to EX: hilo_o, cnt_o                registered partial result/count
// Modports:
//   master - the pipeline around the register (drives ex_*, hilo_i, cnt_i)
//   slave  - the EX/MEM register itself
// ---------------------------------------------------------------------------
interface ex_mem_if
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
);

    logic [REG_AW-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic                ex_whilo;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [CNT_W-1:0]    cnt_i;

    logic [REG_AW-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [CNT_W-1:0]    cnt_o;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               hilo_o, cnt_o
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               hilo_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// ---------------------------------------------------------------------------
// ex_mem
// EX/MEM pipeline register. Every output is a flop; there is no
// combinational path from any input to any output.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   rst   - synchronous, active-high; zeroes every output
//   stall - stall vector, bit 3 = EX stalled, bit 4 = MEM stalled
//   flush - discard the in-flight instruction (zero everything)
//   bus   - ex_mem_if.slave: ex_* in, mem_* out, accumulate hilo/cnt loop
// Per-edge behaviour (priority rst > flush > stall > advance):
//   advance : mem_* <= ex_*, hilo_o/cnt_o cleared
//   bubble  : mem_* <= 0, hilo_o/cnt_o <= hilo_i/cnt_i (EX stalled, MEM not)
//   hold    : everything keeps its value (EX and MEM both stalled)
//   flush   : everything zeroed
// Configuration macro EX_MEM_MADD_EN:
//   defined   - hilo_o/cnt_o are registers carrying the accumulate state
//   undefined - hilo_o/cnt_o are tied to 0 and hilo_i/cnt_i are ignored
// ---------------------------------------------------------------------------
module ex_mem
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    ex_mem_if.slave            bus
);

    stage_act_e act;

    logic [REG_AW-1:0] mem_wd_q,    mem_wd_d;
    logic              mem_wreg_q,  mem_wreg_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_whilo_q, mem_whilo_d;
    logic [DATA_W-1:0] mem_hi_q,    mem_hi_d;
    logic [DATA_W-1:0] mem_lo_q,    mem_lo_d;

    // Stall bits other than EX/MEM carry no meaning for this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

    // Decide once per cycle what the register does on the coming edge.
    always_comb begin
        act = decode_action(flush, stall);
    end

    // Next-state for the forward path into MEM. A bubble and a flush look
    // the same from MEM's point of view: no write, all fields zero.
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        case (act)
            ACT_ADVANCE: begin
                mem_wd_d    = bus.ex_wd;
                mem_wreg_d  = bus.ex_wreg;
                mem_wdata_d = bus.ex_wdata;
                mem_whilo_d = bus.ex_whilo;
                mem_hi_d    = bus.ex_hi;
                mem_lo_d    = bus.ex_lo;
            end
            ACT_BUBBLE, ACT_FLUSH: begin
                mem_wd_d    = '0;
                mem_wreg_d  = 1'b0;
                mem_wdata_d = '0;
                mem_whilo_d = 1'b0;
                mem_hi_d    = '0;
                mem_lo_d    = '0;
            end
            default: begin
            end
        endcase
    end

    // Forward-path flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_whilo_q <= 1'b0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_whilo_q <= mem_whilo_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
        end
    end

    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_wreg  = mem_wreg_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_whilo = mem_whilo_q;
    assign bus.mem_hi    = mem_hi_q;
    assign bus.mem_lo    = mem_lo_q;

`ifdef EX_MEM_MADD_EN
    logic [2*DATA_W-1:0] hilo_q, hilo_d;
    logic [CNT_W-1:0]    cnt_q,  cnt_d;

    // The accumulate loop: while EX is stalled on a multi-cycle op the
    // partial result is parked here and handed back to EX next cycle. Once
    // the op leaves EX (advance) or is killed (flush) the state is dropped.
    always_comb begin
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
        case (act)
            ACT_ADVANCE, ACT_FLUSH: begin
                hilo_d = '0;
                cnt_d  = ZERO_CNT;
            end
            ACT_BUBBLE: begin
                hilo_d = bus.hilo_i;
                cnt_d  = bus.cnt_i;
            end
            default: begin
            end
        endcase
    end

    // Accumulate-state flops; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_q <= '0;
            cnt_q  <= ZERO_CNT;
        end else begin
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.hilo_o = hilo_q;
    assign bus.cnt_o  = cnt_q;
`else
    // Without the accumulate feature the loop back to EX is constant zero.
    logic unused_madd_inputs;
    assign unused_madd_inputs = ^{bus.hilo_i, bus.cnt_i};

    assign bus.hilo_o = '0;
    assign bus.cnt_o  = ZERO_CNT;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// ---------------------------------------------------------------------------
// tb_ex_mem
// Directed checks of the EX/MEM pipeline register. Expected values for
// hilo_o/cnt_o follow the build: with EX_MEM_MADD_EN they carry the
// accumulate state, without it they are always zero.
// ---------------------------------------------------------------------------
module tb_ex_mem;
    import cpu_defs_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef EX_MEM_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;

    int tests_run;
    int tests_failed;

    ex_mem_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    ex_mem #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected accumulate value given the build.
    function automatic logic [63:0] exp_madd(input logic [63:0] v);
        return MADD ? v : 64'd0;
    endfunction

    // Drive control inputs, take one rising edge, then settle 1 time unit.
    task automatic applyStimulus(input logic rs, input logic fl,
                                 input logic [STALL_W-1:0] st);
        rst   = rs;
        flush = fl;
        stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo,
                          input logic [31:0] hi, input logic [31:0] lo);
        bus.ex_wd    = wd;
        bus.ex_wreg  = wreg;
        bus.ex_wdata = wdata;
        bus.ex_whilo = whilo;
        bus.ex_hi    = hi;
        bus.ex_lo    = lo;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, ".mem_wd"},    64'(bus.mem_wd),    64'd0);
        checkOutput({tag, ".mem_wreg"},  64'(bus.mem_wreg),  64'd0);
        checkOutput({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        checkOutput({tag, ".mem_whilo"}, 64'(bus.mem_whilo), 64'd0);
        checkOutput({tag, ".mem_hi"},    64'(bus.mem_hi),    64'd0);
        checkOutput({tag, ".mem_lo"},    64'(bus.mem_lo),    64'd0);
        checkOutput({tag, ".hilo_o"},    bus.hilo_o,         64'd0);
        checkOutput({tag, ".cnt_o"},     64'(bus.cnt_o),     64'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        flush = 1'b0;
        stall = '0;
        set_ex(5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 32'h1111_1111, 32'h2222_2222);
        bus.hilo_i = 64'h0000_0003_0000_0004;
        bus.cnt_i  = 2'd3;

        // Reset with live inputs: everything zero.
        applyStimulus(1'b1, 1'b0, 6'b000000);
        check_all_zero("reset");

        // Normal advance.
        set_ex(5'd5, 1'b1, 32'h12345678, 1'b1, 32'h0000_00AA, 32'h0000_00BB);
        applyStimulus(1'b0, 1'b0, 6'b000000);
        checkOutput("adv.mem_wd",    64'(bus.mem_wd),    64'd5);
        checkOutput("adv.mem_wreg",  64'(bus.mem_wreg),  64'd1);
        checkOutput("adv.mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
        checkOutput("adv.mem_whilo", 64'(bus.mem_whilo), 64'd1);
        checkOutput("adv.mem_hi",    64'(bus.mem_hi),    64'hAA);
        checkOutput("adv.mem_lo",    64'(bus.mem_lo),    64'hBB);
        checkOutput("adv.hilo_o",    bus.hilo_o,         64'd0);
        checkOutput("adv.cnt_o",     64'(bus.cnt_o),     64'd0);

        // Outputs must not follow inputs between edges.
        set_ex(5'd9, 1'b0, 32'h0BAD_F00D, 1'b0, 32'd0, 32'd0);
        stall = 6'b001000;
        #2;
        checkOutput("nocomb.mem_wd",    64'(bus.mem_wd),    64'd5);
        checkOutput("nocomb.mem_wdata", 64'(bus.mem_wdata), 64'h12345678);

        // Bubble: MEM gets a no-op, accumulate state is parked.
        set_ex(5'd9, 1'b1, 32'h0BAD_F00D, 1'b1, 32'd1, 32'd2);
        bus.hilo_i = 64'h0000_0001_FFFF_FFFE;
        bus.cnt_i  = 2'd1;
        applyStimulus(1'b0, 1'b0, 6'b001000);
        checkOutput("bub.mem_wreg",  64'(bus.mem_wreg),  64'd0);
        checkOutput("bub.mem_wdata", 64'(bus.mem_wdata), 64'd0);
        checkOutput("bub.mem_wd",    64'(bus.mem_wd),    64'd0);
        checkOutput("bub.mem_whilo", 64'(bus.mem_whilo), 64'd0);
        checkOutput("bub.hilo_o",    bus.hilo_o,         exp_madd(64'h0000_0001_FFFF_FFFE));
        checkOutput("bub.cnt_o",     64'(bus.cnt_o),     exp_madd(64'd1));

        // Load A5A5A5A5 then hold three cycles while inputs change.
        set_ex(5'd3, 1'b1, 32'hA5A5A5A5, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 6'b000000);
        checkOutput("load.mem_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
        checkOutput("load.cnt_o",     64'(bus.cnt_o),     64'd0);
        set_ex(5'd12, 1'b0, 32'hFFFF0000, 1'b1, 32'h5, 32'h6);
        bus.hilo_i = 64'h1234_5678_9ABC_DEF0;
        bus.cnt_i  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 6'b011000);
            checkOutput($sformatf("hold%0d.mem_wdata", i), 64'(bus.mem_wdata), 64'hA5A5A5A5);
            checkOutput($sformatf("hold%0d.mem_wd", i),    64'(bus.mem_wd),    64'd3);
            checkOutput($sformatf("hold%0d.mem_wreg", i),  64'(bus.mem_wreg),  64'd1);
            checkOutput($sformatf("hold%0d.hilo_o", i),    bus.hilo_o,         64'd0);
        end

        // Bubble loads accumulate state, then hold keeps it.
        bus.hilo_i = 64'h0000_0002_0000_0003;
        bus.cnt_i  = 2'd2;
        applyStimulus(1'b0, 1'b0, 6'b001000);
        checkOutput("bub2.hilo_o", bus.hilo_o,     exp_madd(64'h0000_0002_0000_0003));
        checkOutput("bub2.cnt_o",  64'(bus.cnt_o), exp_madd(64'd2));
        bus.hilo_i = 64'h9999_9999_9999_9999;
        bus.cnt_i  = 2'd3;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 6'b011000);
            checkOutput($sformatf("hold_acc%0d.hilo_o", i), bus.hilo_o,     exp_madd(64'h0000_0002_0000_0003));
            checkOutput($sformatf("hold_acc%0d.cnt_o", i),  64'(bus.cnt_o), exp_madd(64'd2));
        end

        // Illegal MEM-only stall acts as advance.
        set_ex(5'd17, 1'b1, 32'hCAFE_0001, 1'b1, 32'h1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 6'b010000);
        checkOutput("ill.mem_wd",    64'(bus.mem_wd),    64'd17);
        checkOutput("ill.mem_wdata", 64'(bus.mem_wdata), 64'hCAFE_0001);
        checkOutput("ill.mem_lo",    64'(bus.mem_lo),    64'hFFFF_FFFF);
        checkOutput("ill.cnt_o",     64'(bus.cnt_o),     64'd0);
        checkOutput("ill.hilo_o",    bus.hilo_o,         64'd0);

        // Unrelated stall bits are ignored.
        set_ex(5'd31, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'b100111);
        checkOutput("ign.mem_wd",    64'(bus.mem_wd),    64'd31);
        checkOutput("ign.mem_wdata", 64'(bus.mem_wdata), 64'h8000_0000);
        checkOutput("ign.mem_whilo", 64'(bus.mem_whilo), 64'd0);

        // Flush beats hold.
        set_ex(5'd4, 1'b1, 32'h0000_0044, 1'b1, 32'h1, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'b000000);
        checkOutput("preflush.mem_whilo", 64'(bus.mem_whilo), 64'd1);
        checkOutput("preflush.mem_hi",    64'(bus.mem_hi),    64'd1);
        applyStimulus(1'b0, 1'b1, 6'b011000);
        check_all_zero("flush_hold");

        // Flush beats bubble: accumulate state not loaded.
        bus.hilo_i = 64'h0000_0005_0000_0006;
        bus.cnt_i  = 2'd3;
        applyStimulus(1'b0, 1'b1, 6'b001000);
        check_all_zero("flush_bub");

        // Reset in the middle of an accumulate discards it.
        bus.cnt_i = 2'd2;
        applyStimulus(1'b0, 1'b0, 6'b001000);
        checkOutput("acc.cnt_o", 64'(bus.cnt_o), exp_madd(64'd2));
        applyStimulus(1'b1, 1'b0, 6'b001000);
        check_all_zero("rst_acc");

        // Reset beats flush and advance with live data.
        set_ex(5'd1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h7, 32'h8);
        applyStimulus(1'b1, 1'b1, 6'b000000);
        check_all_zero("rst_last");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
